// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Purpose  : Eight-digit multiplexed 7-segment scan controller with a
//            write-addressable digit buffer. Optional inter-digit blanking
//            is enabled by defining SEG_SCAN_BLANK_EN.
// Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int F_CLK     = 50000000,
  parameter int F_SCAN    = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_valid,
  output logic       o_wr_ready,
  input  logic [2:0] i_wr_addr,
  input  logic [3:0] i_wr_data,
  input  logic       i_wr_dot,
  output logic [7:0] o_cs,
  output logic [7:0] o_dig_sel,
  output logic       o_scan_tick
);

  localparam int              c_TC    = F_CLK / F_SCAN - 1;
  localparam int              c_PW    = (c_TC > 0) ? $clog2(c_TC + 1) : 1;
  localparam logic [c_PW-1:0] c_TC_M1 = c_PW'(c_TC - 1);
  localparam logic [c_PW-1:0] c_ONE   = c_PW'(1);

  logic [c_PW-1:0] r_presc;
  logic            r_tick;
  logic            r_ready;
  logic [2:0]      r_ptr;
  logic [3:0]      r_val [8];
  logic [7:0]      r_dot;
  logic [7:0]      r_cs;
  logic [7:0]      r_seg;

  logic            w_fire;
  logic [2:0]      w_ptr_nxt;
  logic            w_show_nxt;
  logic            w_fwd;
  logic [3:0]      w_val_sel;
  logic            w_dot_sel;
  logic [6:0]      w_seg7;

  assign w_fire    = i_wr_valid & r_ready;
  assign w_ptr_nxt = r_tick ? (r_ptr + 3'd1) : r_ptr;

`ifdef SEG_SCAN_BLANK_EN
  localparam logic [0:0] c_SHOW  = 1'b0;
  localparam logic [0:0] c_BLANK = 1'b1;
  localparam int         c_BW    = $clog2(BLANK_CYC + 1);
  localparam logic [c_BW-1:0] c_BLAST = c_BW'(BLANK_CYC - 1);

  logic [0:0]      r_state;
  logic [0:0]      w_state_nxt;
  logic [c_BW-1:0] r_bcnt;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_SHOW:  if (r_tick) w_state_nxt = c_BLANK;
      c_BLANK: if (r_bcnt == c_BLAST) w_state_nxt = c_SHOW;
      default: w_state_nxt = c_SHOW;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= c_SHOW;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_bcnt  <= (r_state == c_BLANK && w_state_nxt == c_BLANK) ? r_bcnt + c_BW'(1) : '0;
    end
  end

  assign w_show_nxt = (w_state_nxt == c_SHOW);
  // A write landing on the BLANK->SHOW edge must appear in the first SHOW cycle.
  assign w_fwd      = (r_state == c_BLANK);
`else
  assign w_show_nxt = 1'b1;
  assign w_fwd      = 1'b0;
`endif

  always_comb begin
    w_val_sel = r_val[w_ptr_nxt];
    w_dot_sel = r_dot[w_ptr_nxt];
    if (w_fwd && w_fire && (i_wr_addr == w_ptr_nxt)) begin
      w_val_sel = i_wr_data;
      w_dot_sel = i_wr_dot;
    end
  end

  // Active-low segments in {g,f,e,d,c,b,a} order.
  always_comb begin
    w_seg7 = 7'h7F;
    case (w_val_sel)
      4'h0: w_seg7 = 7'h40;
      4'h1: w_seg7 = 7'h79;
      4'h2: w_seg7 = 7'h24;
      4'h3: w_seg7 = 7'h30;
      4'h4: w_seg7 = 7'h19;
      4'h5: w_seg7 = 7'h12;
      4'h6: w_seg7 = 7'h02;
      4'h7: w_seg7 = 7'h78;
      4'h8: w_seg7 = 7'h00;
      4'h9: w_seg7 = 7'h10;
      4'hA: w_seg7 = 7'h08;
      4'hB: w_seg7 = 7'h03;
      4'hC: w_seg7 = 7'h46;
      4'hD: w_seg7 = 7'h21;
      4'hE: w_seg7 = 7'h06;
      4'hF: w_seg7 = 7'h0E;
      default: w_seg7 = 7'h7F;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
      r_ready <= 1'b0;
      r_ptr   <= 3'd0;
      r_dot   <= 8'h00;
      r_cs    <= 8'hFF;
      r_seg   <= 8'hFF;
      for (int i = 0; i < 8; i++) r_val[i] <= 4'h0;
    end else begin
      r_presc <= r_tick ? '0 : r_presc + c_ONE;
      // Tick and ready are pre-decoded so both are clean registered flags.
      r_tick  <= (r_presc == c_TC_M1);
      r_ready <= (r_presc != c_TC_M1);
      r_ptr   <= w_ptr_nxt;
      if (w_fire) begin
        r_val[i_wr_addr] <= i_wr_data;
        r_dot[i_wr_addr] <= i_wr_dot;
      end
      r_cs  <= w_show_nxt ? ~(8'h01 << w_ptr_nxt) : 8'hFF;
      r_seg <= w_show_nxt ? {~w_dot_sel, w_seg7} : 8'hFF;
    end
  end

  assign o_wr_ready  = r_ready;
  assign o_cs        = r_cs;
  assign o_dig_sel   = r_seg;
  assign o_scan_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Purpose  : Self-checking bench for seg_scan_ctrl (scoreboard + vector table).
// Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

  localparam int F_CLK     = 1000;
  localparam int F_SCAN    = 100;
  localparam int BLANK_CYC = 2;
  localparam int TC        = F_CLK / F_SCAN - 1;
`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_dot;
  logic       wr_ready;
  logic       scan_tick;
  logic [7:0] cs;
  logic [7:0] dig;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.F_CLK(F_CLK), .F_SCAN(F_SCAN), .BLANK_CYC(BLANK_CYC)) dut (
    .i_clk(clk), .i_rst(rst), .i_wr_valid(wr_valid), .o_wr_ready(wr_ready),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_dot(wr_dot),
    .o_cs(cs), .o_dig_sel(dig), .o_scan_tick(scan_tick)
  );

  typedef struct {
    logic [7:0] cs;
    logic [7:0] dig;
    logic       tick;
    logic       ready;
  } exp_t;

  typedef struct {
    logic [2:0] addr;
    logic [3:0] data;
    logic       dot;
    logic [7:0] exp;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model state for the current cycle
  logic [3:0] m_val [8];
  logic       m_dot [8];
  int         m_presc, m_ptr, m_bcnt;
  bit         m_show, m_ready;

  function automatic logic [7:0] seg(input logic [3:0] v, input logic d);
    logic [7:0] s;
    case (v)
      4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
      4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
      4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
      4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; default: s = 8'h8E;
    endcase
    if (d) s[7] = 1'b0;
    return s;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_val[i] = 4'h0;
      m_dot[i] = 1'b0;
    end
    m_presc = 0; m_ptr = 0; m_bcnt = 0; m_show = 1'b1; m_ready = 1'b0;
  endtask

  // Advance model one edge, push expectation, clock DUT, pop and compare.
  task automatic step();
    exp_t       e;
    bit         tick, fire, was_show;
    logic [3:0] ov;
    logic       od;
    tick     = (m_presc == TC);
    fire     = wr_valid && m_ready;
    was_show = m_show;
    m_presc  = tick ? 0 : m_presc + 1;
    if (tick) begin
      m_ptr = (m_ptr + 1) % 8;
      if (BLANK_EN) begin
        m_show = 1'b0;
        m_bcnt = 0;
      end
    end else if (!m_show) begin
      if (m_bcnt == BLANK_CYC - 1) m_show = 1'b1;
      else m_bcnt++;
    end
    ov = m_val[m_ptr];
    od = m_dot[m_ptr];
    if (fire) begin
      m_val[wr_addr] = wr_data;
      m_dot[wr_addr] = wr_dot;
    end
    // Entering SHOW from BLANK shows the freshly written value immediately.
    if (!was_show) begin
      ov = m_val[m_ptr];
      od = m_dot[m_ptr];
    end
    m_ready = (m_presc != TC);
    e.cs    = m_show ? ~(8'h01 << m_ptr) : 8'hFF;
    e.dig   = m_show ? seg(ov, od) : 8'hFF;
    e.tick  = (m_presc == TC);
    e.ready = m_ready;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("cs_dig_tick_ready", {cs, dig, scan_tick, wr_ready}, {e.cs, e.dig, e.tick, e.ready});
  endtask

  task automatic pulse_reset(input string tag);
    rst = 1'b1;
    #1;
    check({tag, "_rst_cs"},    {24'h0, cs},  32'hFF);
    check({tag, "_rst_dig"},   {24'h0, dig}, 32'hFF);
    check({tag, "_rst_tick"},  {31'h0, scan_tick}, 32'h0);
    check({tag, "_rst_ready"}, {31'h0, wr_ready},  32'h0);
    repeat (2) @(posedge clk);
    wr_valid = 1'b0;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic wr(input logic [2:0] a, input logic [3:0] d, input logic dt, output int edges);
    bit acc;
    acc   = 1'b0;
    edges = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d; wr_dot = dt;
    for (int n = 0; n < 20; n++) begin
      acc = wr_ready;
      step();
      edges++;
      if (acc) break;
    end
    check("wr_accepted", {31'h0, acc}, 32'h1);
    wr_valid = 1'b0;
  endtask

  initial begin
    vec_t tbl[6];
    int   seen[6];
    int   edges;
    bit   found;
    bit   acc;

    tbl[0] = '{3'd3, 4'hA, 1'b1, 8'h08};
    tbl[1] = '{3'd1, 4'h1, 1'b0, 8'hF9};
    tbl[2] = '{3'd2, 4'h8, 1'b0, 8'h80};
    tbl[3] = '{3'd4, 4'hF, 1'b0, 8'h8E};
    tbl[4] = '{3'd6, 4'h0, 1'b1, 8'h40};
    tbl[5] = '{3'd7, 4'h5, 1'b0, 8'h92};

    rst = 1'b1; wr_valid = 1'b0; wr_addr = 3'd0; wr_data = 4'h0; wr_dot = 1'b0;
    #3;
    pulse_reset("por");

    // First edge after release: digit 0 visible, ready up
    step();
    check("rel_cs",    {24'h0, cs},  32'hFE);
    check("rel_dig",   {24'h0, dig}, 32'hC0);
    check("rel_ready", {31'h0, wr_ready}, 32'h1);

    repeat (90) step();

    // Vector table: write each entry, then scan and check each digit's pattern
    foreach (tbl[i]) wr(tbl[i].addr, tbl[i].data, tbl[i].dot, edges);
    foreach (seen[i]) seen[i] = 0;
    for (int n = 0; n < 90; n++) begin
      step();
      foreach (tbl[i]) begin
        if (cs == ~(8'h01 << tbl[i].addr)) begin
          check("tbl_dig", {24'h0, dig}, {24'h0, tbl[i].exp});
          seen[i]++;
        end
      end
    end
    foreach (seen[i]) check("tbl_digit_seen", {31'h0, seen[i] > 0}, 32'h1);

    // Write held across the tick cycle lands one edge later
    found = 1'b0;
    for (int n = 0; n < 30; n++) begin
      if (scan_tick) begin found = 1'b1; break; end
      step();
    end
    check("tick_found", {31'h0, found}, 32'h1);
    check("ready_low_in_tick", {31'h0, wr_ready}, 32'h0);
    wr(3'd1, 4'h3, 1'b0, edges);
    check("held_write_edges", edges, 32'd2);
    repeat (85) step();

    // Write to the digit currently shown
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (cs == 8'hFE && m_presc >= 3 && m_presc <= 5) begin found = 1'b1; break; end
      step();
    end
    check("digit0_window", {31'h0, found}, 32'h1);
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 4'h8; wr_dot = 1'b0;
    acc = wr_ready;
    step();
    wr_valid = 1'b0;
    check("live_acc", {31'h0, acc}, 32'h1);
    check("live_dig_at_accept", {24'h0, dig}, 32'hC0);
    check("live_cs_at_accept",  {24'h0, cs},  32'hFE);
    step();
    check("live_dig_after", {24'h0, dig}, 32'h80);
    check("live_cs_after",  {24'h0, cs},  32'hFE);

    // Reset right after digit 5 leaves SHOW, with a write pending
    wr(3'd5, 4'hF, 1'b0, edges);
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (cs == 8'hDF) begin found = 1'b1; break; end
      step();
    end
    check("digit5_shown", {31'h0, found}, 32'h1);
    check("digit5_dig", {24'h0, dig}, 32'h8E);
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (cs != 8'hDF) begin found = 1'b1; break; end
      step();
    end
    check("digit5_left", {31'h0, found}, 32'h1);
    wr_valid = 1'b1; wr_addr = 3'd5; wr_data = 4'h9; wr_dot = 1'b1;
    #2;
    pulse_reset("mid");
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      step();
      if (cs == 8'hDF) begin found = 1'b1; break; end
    end
    check("digit5_after_rst", {31'h0, found}, 32'h1);
    check("digit5_cleared", {24'h0, dig}, 32'hC0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
